// File: rtl/sensor_pulse_counter.sv
// -----------------------------------------------------------------------------
// sensor_pulse_counter
//
// Gated edge counter for an asynchronous sensor input. The sensor line is
// synchronized, edge-detected and accumulated over a window of gate_cycles
// ACLK cycles. Continuous mode can re-arm the window automatically. The result
// and the sticky status flags are presented to a register file for read-back.
//
// Parameters
//   CNT_WIDTH    width of the edge accumulator and count_out
//   GATE_WIDTH   width of gate_cycles and the window timer
//   SYNC_STAGES  synchronizer depth on sensor_in (must be >= 2)
//
// Ports
//   ACLK             clock, rising edge
//   ARESET           asynchronous active-high reset
//   sensor_in        asynchronous sensor pulse input
//   ctrl_enable      counting permitted while high; low aborts a window
//   ctrl_start       one-cycle start request
//   ctrl_both_edges  0: rising edges only, 1: rising and falling edges
//   ctrl_continuous  re-arm automatically at the end of each window
//   gate_cycles      window length in ACLK cycles (sampled on each load)
//   count_out        result of the last completed window
//   count_valid      one-cycle pulse coincident with a count_out update
//   busy             high while a window is running
//   done             sticky window-complete flag, cleared by accepted start
//   overflow         sticky saturation flag of the last completed window
// -----------------------------------------------------------------------------
module sensor_pulse_counter #(
  parameter int CNT_WIDTH   = 32,
  parameter int GATE_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  sensor_in,
  input  logic                  ctrl_enable,
  input  logic                  ctrl_start,
  input  logic                  ctrl_both_edges,
  input  logic                  ctrl_continuous,
  input  logic [GATE_WIDTH-1:0] gate_cycles,
  output logic [CNT_WIDTH-1:0]  count_out,
  output logic                  count_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state_reg, state_next;

  // ---------------------------------------------------------------------------
  // Synchronizer chain plus one history flop for edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sync_reg[0] <= 1'b0;
    end else begin
      sync_reg[0] <= sensor_in;
    end
  end

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          sync_reg[gi] <= 1'b0;
        end else begin
          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      hist_reg <= 1'b0;
    end else begin
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  logic sync_out;
  logic rise_det;
  logic fall_det;
  logic edge_det;

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign rise_det = sync_out & ~hist_reg;
  assign fall_det = ~sync_out & hist_reg;
  assign edge_det = rise_det | (ctrl_both_edges & fall_det);

  // ---------------------------------------------------------------------------
  // Window datapath registers
  // ---------------------------------------------------------------------------
  logic [GATE_WIDTH-1:0] timer_reg,       timer_next;
  logic [CNT_WIDTH-1:0]  acc_reg,         acc_next;
  logic                  ovf_int_reg,     ovf_int_next;
  logic [CNT_WIDTH-1:0]  count_out_reg,   count_out_next;
  logic                  count_valid_reg, count_valid_next;
  logic                  done_reg,        done_next;
  logic                  overflow_reg,    overflow_next;

  logic                  gate_nz;
  logic                  start_ok;
  logic                  timer_zero;
  logic                  acc_full;
  logic                  sat_now;
  logic [CNT_WIDTH-1:0]  acc_plus;
  logic [GATE_WIDTH-1:0] gate_load;

  assign gate_nz    = (gate_cycles != '0);
  assign start_ok   = ctrl_start & ctrl_enable & gate_nz;
  assign timer_zero = (timer_reg == '0);
  assign gate_load  = gate_cycles - GATE_WIDTH'(1);

  // Saturating increment: at all-ones the value holds and the edge is
  // reported as a saturation event instead.
  assign acc_full = (acc_reg == CNT_MAX);
  assign sat_now  = edge_det & acc_full;
  assign acc_plus = acc_reg + CNT_WIDTH'(edge_det & ~acc_full);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    timer_next       = timer_reg;
    acc_next         = acc_reg;
    ovf_int_next     = ovf_int_reg;
    count_out_next   = count_out_reg;
    count_valid_next = 1'b0;
    done_next        = done_reg;
    overflow_next    = overflow_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start_ok) begin
          state_next    = ST_COUNT;
          timer_next    = gate_load;
          acc_next      = '0;
          ovf_int_next  = 1'b0;
          done_next     = 1'b0;
          overflow_next = 1'b0;
        end
      end

      ST_COUNT: begin
        if (!ctrl_enable) begin
          // Abort: discard the partial window, leave published results alone.
          state_next = ST_IDLE;
        end else if (timer_zero) begin
          // Last window cycle: this cycle's edge is still part of the result.
          count_out_next   = acc_plus;
          overflow_next    = ovf_int_reg | sat_now;
          count_valid_next = 1'b1;
          done_next        = 1'b1;
          if (ctrl_continuous && gate_nz) begin
            // Back-to-back window, no dead cycle between them.
            timer_next   = gate_load;
            acc_next     = '0;
            ovf_int_next = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          timer_next   = timer_reg - GATE_WIDTH'(1);
          acc_next     = acc_plus;
          ovf_int_next = ovf_int_reg | sat_now;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      timer_reg       <= '0;
      acc_reg         <= '0;
      ovf_int_reg     <= 1'b0;
      count_out_reg   <= '0;
      count_valid_reg <= 1'b0;
      done_reg        <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      timer_reg       <= timer_next;
      acc_reg         <= acc_next;
      ovf_int_reg     <= ovf_int_next;
      count_out_reg   <= count_out_next;
      count_valid_reg <= count_valid_next;
      done_reg        <= done_next;
      overflow_reg    <= overflow_next;
    end
  end

  assign count_out   = count_out_reg;
  assign count_valid = count_valid_reg;
  assign busy        = (state_reg == ST_COUNT);
  assign done        = done_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_sensor_pulse_counter.sv
// -----------------------------------------------------------------------------
// tb_sensor_pulse_counter
//
// Directed bench for sensor_pulse_counter with an 8-bit accumulator so that
// saturation is reachable. ACLK runs at 100 MHz; the sensor is either a
// free-running square wave or a manually driven level.
// -----------------------------------------------------------------------------
module tb_sensor_pulse_counter;

  localparam int CW = 8;
  localparam int GW = 32;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          sensor_in;
  logic          ctrl_enable = 1'b0;
  logic          ctrl_start = 1'b0;
  logic          ctrl_both_edges = 1'b0;
  logic          ctrl_continuous = 1'b0;
  logic [GW-1:0] gate_cycles = '0;
  logic [CW-1:0] count_out;
  logic          count_valid;
  logic          busy;
  logic          done;
  logic          overflow;

  int vectors = 0;
  int miscompares = 0;

  // Sensor source: square wave generator or manual level
  int   half_ns = 50;
  logic gen_sig = 1'b0;
  logic gen_on  = 1'b1;
  logic man_sig = 1'b0;

  assign sensor_in = gen_on ? gen_sig : man_sig;

  always #5 ACLK = ~ACLK;

  initial begin
    #2;
    forever begin
      #(half_ns) gen_sig = ~gen_sig;
    end
  end

  sensor_pulse_counter #(
    .CNT_WIDTH  (CW),
    .GATE_WIDTH (GW),
    .SYNC_STAGES(2)
  ) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .sensor_in      (sensor_in),
    .ctrl_enable    (ctrl_enable),
    .ctrl_start     (ctrl_start),
    .ctrl_both_edges(ctrl_both_edges),
    .ctrl_continuous(ctrl_continuous),
    .gate_cycles    (gate_cycles),
    .count_out      (count_out),
    .count_valid    (count_valid),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("vec %0d %s: observed %0d expected %0d", vectors, tag, obs, exp);
  endtask

  // Called at a falling edge; the start is sampled at the next rising edge N
  // and the task returns at the falling edge inside cycle N+1.
  task automatic pulse_start();
    ctrl_start = 1'b1;
    @(negedge ACLK);
    ctrl_start = 1'b0;
  endtask

  // Cycles counted from cycle N+1 (=1) until count_valid is seen, bounded.
  task automatic wait_valid(input int limit, output int cycles);
    cycles = 1;
    while (count_valid !== 1'b1 && cycles < limit) begin
      @(negedge ACLK);
      cycles++;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  int cyc;
  int nvalid;

  initial begin
    // ---------------- reset state ----------------
    #1;
    check("rst_busy",     busy,        0);
    check("rst_done",     done,        0);
    check("rst_overflow", overflow,    0);
    check("rst_valid",    count_valid, 0);
    check("rst_count",    count_out,   0);
    idle_cycles(3);
    ARESET = 1'b0;
    ctrl_enable = 1'b1;
    idle_cycles(10);

    // ---------------- basic: rising edges, 1000-cycle window ----------------
    gate_cycles = 1000;
    pulse_start();
    check("basic_busy_n1", busy, 1);
    wait_valid(2000, cyc);
    check("basic_latency",  cyc,       1001);
    check("basic_count",    count_out, 100);
    check("basic_done",     done,      1);
    check("basic_overflow", overflow,  0);
    check("basic_busy_end", busy,      0);
    @(negedge ACLK);
    check("basic_valid_width", count_valid, 0);

    // ---------------- start with gate_cycles=0 ignored ----------------
    gate_cycles = 0;
    pulse_start();
    check("gate0_busy", busy, 0);
    check("gate0_done", done, 1);
    idle_cycles(5);

    // ---------------- second start while busy ignored ----------------
    gate_cycles = 1000;
    pulse_start();
    idle_cycles(199);
    gate_cycles = 50;
    pulse_start();
    wait_valid(2000, cyc);
    check("restart_latency", cyc + 200, 1001);
    check("restart_count",   count_out, 100);
    idle_cycles(5);

    // ---------------- both edges + continuous, then abort ----------------
    gate_cycles = 1000;
    ctrl_both_edges = 1'b1;
    ctrl_continuous = 1'b1;
    pulse_start();
    wait_valid(2000, cyc);
    check("cont_latency1", cyc,       1001);
    check("cont_count1",   count_out, 200);
    check("cont_busy1",    busy,      1);
    @(negedge ACLK);
    wait_valid(2000, cyc);
    check("cont_latency2", cyc + 1,   1001);
    check("cont_count2",   count_out, 200);
    check("cont_busy2",    busy,      1);
    idle_cycles(300);
    ctrl_enable = 1'b0;
    @(negedge ACLK);
    check("abort_busy", busy, 0);
    nvalid = 0;
    for (int i = 0; i < 1200; i++) begin
      if (count_valid === 1'b1) nvalid++;
      @(negedge ACLK);
    end
    check("abort_no_valid", nvalid,    0);
    check("abort_count",    count_out, 200);
    check("abort_done",     done,      1);
    ctrl_enable = 1'b1;
    ctrl_both_edges = 1'b0;
    ctrl_continuous = 1'b0;

    // ---------------- saturation: 325 rising edges into 8 bits ----------------
    half_ns = 20;
    idle_cycles(20);
    gate_cycles = 1300;
    pulse_start();
    wait_valid(2000, cyc);
    check("sat_latency",  cyc,       1301);
    check("sat_count",    count_out, 255);
    check("sat_overflow", overflow,  1);
    half_ns = 50;
    idle_cycles(20);
    gate_cycles = 1000;
    pulse_start();
    check("sat_clr_overflow", overflow, 0);
    check("sat_clr_done",     done,     0);
    wait_valid(2000, cyc);
    check("post_sat_count",    count_out, 100);
    check("post_sat_overflow", overflow,  0);

    // ---------------- gate_cycles=1 with one edge in the window ----------------
    gen_on = 1'b0;
    man_sig = 1'b0;
    idle_cycles(10);
    gate_cycles = 1;
    man_sig = 1'b1;           // detect pulse arrives in cycle N+1
    @(negedge ACLK);
    pulse_start();
    wait_valid(10, cyc);
    check("gate1_latency", cyc,       2);
    check("gate1_count",   count_out, 1);
    idle_cycles(5);

    // ---------------- reset mid-window ----------------
    gen_on = 1'b1;
    idle_cycles(20);
    gate_cycles = 1000;
    pulse_start();
    idle_cycles(499);
    ARESET = 1'b1;
    #1;
    check("mid_rst_busy",     busy,        0);
    check("mid_rst_done",     done,        0);
    check("mid_rst_overflow", overflow,    0);
    check("mid_rst_valid",    count_valid, 0);
    check("mid_rst_count",    count_out,   0);
    idle_cycles(2);
    ARESET = 1'b0;
    idle_cycles(5);
    pulse_start();
    wait_valid(2000, cyc);
    check("post_rst_latency", cyc,       1001);
    check("post_rst_count",   count_out, 100);
    check("post_rst_done",    done,      1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
